// File: rtl/zx_pkg.sv
// -----------------------------------------------------------------------------
// zx_pkg
// Shared definitions for the ZX 128K / Pentagon / +3 memory pager:
//   - IO port match masks/values for #7FFD and #1FFD
//   - write-strobe FSM state encodings
//   - paging register bundle
//   - +3 special (all-RAM) paging table and #7FFD bank-bit gather helper
// -----------------------------------------------------------------------------
package zx_pkg;

   // Partial decode: only the listed address bits take part in the match.
   localparam logic [15:0] PORT_7FFD_MASK = 16'hC002;  // a15, a14, a1
   localparam logic [15:0] PORT_7FFD_VAL  = 16'h4000;  // a15=0, a14=1, a1=0
   localparam logic [15:0] PORT_1FFD_MASK = 16'hF002;  // a15:12, a1
   localparam logic [15:0] PORT_1FFD_VAL  = 16'h1000;  // a15:12=0001, a1=0

   // Write-strobe FSM states.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_QUAL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Paging state other than the RAM bank, whose width is a parameter.
   typedef struct packed {
      logic       vbank;    // screen bank
      logic       rom_lo;   // ROM bank low bit (#7FFD[4])
      logic       lock;     // sticky #7FFD lock
      logic       special;  // +3 all-RAM paging enable
      logic [1:0] cfg;      // +3 special configuration
      logic       rom_hi;   // ROM bank high bit (#1FFD[2])
   } pager_regs_t;

   // Special paging pages, 3 bits per entry, indexed by {cfg, window}.
   // From most- to least-significant entry: cfg3 w3..w0, cfg2, cfg1, cfg0.
   localparam logic [47:0] SPECIAL_MAP = {
      3'd3, 3'd6, 3'd7, 3'd4,
      3'd3, 3'd6, 3'd5, 3'd4,
      3'd7, 3'd6, 3'd5, 3'd4,
      3'd3, 3'd2, 3'd1, 3'd0
   };

   function automatic logic [2:0] special_page(input logic [1:0] cfg,
                                               input logic [1:0] win);
      return SPECIAL_MAP[int'({cfg, win}) * 3 +: 3];
   endfunction

   // Gather every candidate bank bit of a #7FFD write into one 6-bit value;
   // the pager keeps only its low RAM_BANK_BITS, which selects the Pentagon
   // extension bits {d5, d7, d6} in order of increasing memory size.
   function automatic logic [5:0] bank_from_7ffd(input logic [7:0] d);
      return {d[5], d[7], d[6], d[2:0]};
   endfunction

endpackage

// File: rtl/zx_io_wr_strobe.sv
// -----------------------------------------------------------------------------
// zx_io_wr_strobe
// Qualifies a Z80 IO write and emits exactly one load pulse per IO cycle,
// however many wait states stretch it.
//   clkcpu  in  CPU clock
//   rst_n   in  asynchronous active-low reset
//   n_iorq  in  Z80 IORQ (active low)
//   n_wr    in  Z80 WR   (active low)
//   n_m1    in  Z80 M1   (active low; low with IORQ = interrupt acknowledge)
//   load    out high during the cycle whose closing edge loads the registers
// -----------------------------------------------------------------------------
module zx_io_wr_strobe
   import zx_pkg::*;
(
   input  logic clkcpu,
   input  logic rst_n,
   input  logic n_iorq,
   input  logic n_wr,
   input  logic n_m1,
   output logic load
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       wr_act;

   assign wr_act = ~n_iorq & ~n_wr & n_m1;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: next state defaults to the current state before the case, so no
   // path leaves state_nxt unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (wr_act) state_nxt = ST_QUAL;
         ST_QUAL: state_nxt = wr_act ? ST_DONE : ST_IDLE;
         ST_DONE: if (n_iorq) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The QUAL->DONE edge is the load edge; DONE holds off further loads
   // until IORQ is released.
   assign load = (state == ST_QUAL) & wr_act;

endmodule

// File: rtl/zx_mem_pager.sv
// -----------------------------------------------------------------------------
// zx_mem_pager
// Paging controller for the ZX 128K family. Decodes writes to #7FFD/#1FFD,
// holds the paging registers and maps the CPU address window a[15:14] to a
// physical RAM page or the ROM.
//   clkcpu     in  CPU clock, all state on rising edge
//   rst_n      in  asynchronous active-low reset
//   a, d       in  CPU address / data bus
//   n_iorq, n_mreq, n_wr, n_m1  in  Z80 control strobes (active low)
//   page       out physical RAM page for the current window
//   rom_bank   out ROM bank select
//   n_romcs    out ROM chip select (active low)
//   vbank      out screen bank
//   contended  out current access hits a contended page
//   lock       out #7FFD lock status
// -----------------------------------------------------------------------------
module zx_mem_pager
   import zx_pkg::*;
#(
   parameter int RAM_BANK_BITS = 3,
   parameter int ROM_BANK_BITS = 1,
   parameter int EN_1FFD       = 0
) (
   input  logic                     clkcpu,
   input  logic                     rst_n,
   input  logic [15:0]              a,
   input  logic [7:0]               d,
   input  logic                     n_iorq,
   input  logic                     n_mreq,
   input  logic                     n_wr,
   input  logic                     n_m1,
   output logic [RAM_BANK_BITS-1:0] page,
   output logic [ROM_BANK_BITS-1:0] rom_bank,
   output logic                     n_romcs,
   output logic                     vbank,
   output logic                     contended,
   output logic                     lock
);

   localparam bit HAS_1FFD = (EN_1FFD != 0);
   // With 6 bank bits, d[5] becomes a bank bit and the lock is unavailable.
   localparam bit HAS_LOCK = (RAM_BANK_BITS != 6);

   logic                     load;
   logic                     sel_7ffd;
   logic                     sel_1ffd;
   logic [RAM_BANK_BITS-1:0] bank;
   pager_regs_t              regs;
   logic [1:0]               win;
   logic                     win_is_rom;

   zx_io_wr_strobe u_wr_strobe (
      .clkcpu (clkcpu),
      .rst_n  (rst_n),
      .n_iorq (n_iorq),
      .n_wr   (n_wr),
      .n_m1   (n_m1),
      .load   (load)
   );

   assign sel_7ffd = n_m1 & ((a & PORT_7FFD_MASK) == PORT_7FFD_VAL);
   assign sel_1ffd = HAS_1FFD & n_m1 & ((a & PORT_1FFD_MASK) == PORT_1FFD_VAL);

   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         bank <= '0;
         regs <= '0;
      end else if (load && !regs.lock) begin
         if (sel_7ffd) begin
            bank        <= RAM_BANK_BITS'(bank_from_7ffd(d));
            regs.vbank  <= d[3];
            regs.rom_lo <= d[4];
            regs.lock   <= HAS_LOCK & d[5];
         end else if (sel_1ffd) begin
            regs.special <= d[0];
            regs.cfg     <= d[2:1];
            regs.rom_hi  <= d[2];
         end
      end
   end

   // Window map, purely combinational so the page follows the address.
   always_comb begin
      win        = a[15:14];
      win_is_rom = ~regs.special & (win == 2'b00);
      page       = '0;
      if (regs.special) begin
         page = RAM_BANK_BITS'(special_page(regs.cfg, win));
      end else begin
         case (win)
            2'b01:   page = RAM_BANK_BITS'(3'd5);
            2'b10:   page = RAM_BANK_BITS'(3'd2);
            2'b11:   page = bank;
            default: page = '0;
         endcase
      end
   end

   assign n_romcs   = n_mreq | a[15] | a[14] | regs.special;
   // 128K contends odd pages; +3 contends pages 4..7.
   assign contended = ~n_mreq & ~win_is_rom & (HAS_1FFD ? page[2] : page[0]);
   assign vbank     = regs.vbank;
   assign lock      = regs.lock;

   generate
      if (ROM_BANK_BITS == 2) begin : g_rom2
         assign rom_bank = {regs.rom_hi, regs.rom_lo};
      end else begin : g_rom1
         assign rom_bank = regs.rom_lo;
      end
   endgenerate

endmodule

// File: tb/tb_zx_mem_pager.sv
// -----------------------------------------------------------------------------
// tb_zx_mem_pager
// Three pager variants share one Z80 bus: plain 128K, Pentagon-1024
// (6 bank bits, no lock) and +3 (2 ROM bits, #1FFD special paging).
// -----------------------------------------------------------------------------
module tb_zx_mem_pager;

   typedef struct {
      int          dut;        // 0 = 128K, 1 = 1024K, 2 = +3
      logic [15:0] a;
      logic        n_mreq;
      logic [5:0]  page;
      logic        n_romcs;
      logic        contended;
   } vec_t;

   logic        clkcpu = 1'b0;
   logic        rst_n  = 1'b0;
   logic [15:0] a      = 16'h0000;
   logic [7:0]  d      = 8'h00;
   logic        n_iorq = 1'b1;
   logic        n_mreq = 1'b1;
   logic        n_wr   = 1'b1;
   logic        n_m1   = 1'b1;

   logic [2:0] page_128;
   logic [5:0] page_1024;
   logic [2:0] page_p3;
   logic [0:0] rom_128, rom_1024;
   logic [1:0] rom_p3;
   logic       romcs_128, romcs_1024, romcs_p3;
   logic       vbank_128, vbank_1024, vbank_p3;
   logic       cont_128, cont_1024, cont_p3;
   logic       lock_128, lock_1024, lock_p3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clkcpu = ~clkcpu;

   zx_mem_pager #(.RAM_BANK_BITS(3), .ROM_BANK_BITS(1), .EN_1FFD(0)) u_dut128 (
      .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq),
      .n_mreq(n_mreq), .n_wr(n_wr), .n_m1(n_m1), .page(page_128),
      .rom_bank(rom_128), .n_romcs(romcs_128), .vbank(vbank_128),
      .contended(cont_128), .lock(lock_128));

   zx_mem_pager #(.RAM_BANK_BITS(6), .ROM_BANK_BITS(1), .EN_1FFD(0)) u_dut1024 (
      .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq),
      .n_mreq(n_mreq), .n_wr(n_wr), .n_m1(n_m1), .page(page_1024),
      .rom_bank(rom_1024), .n_romcs(romcs_1024), .vbank(vbank_1024),
      .contended(cont_1024), .lock(lock_1024));

   zx_mem_pager #(.RAM_BANK_BITS(3), .ROM_BANK_BITS(2), .EN_1FFD(1)) u_dut_p3 (
      .clkcpu(clkcpu), .rst_n(rst_n), .a(a), .d(d), .n_iorq(n_iorq),
      .n_mreq(n_mreq), .n_wr(n_wr), .n_m1(n_m1), .page(page_p3),
      .rom_bank(rom_p3), .n_romcs(romcs_p3), .vbank(vbank_p3),
      .contended(cont_p3), .lock(lock_p3));

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input int dut, input logic [15:0] addr,
                               input logic mreq, input logic [5:0] pg,
                               input logic romcs, input logic cont);
      vec_t v;
      v.dut = dut; v.a = addr; v.n_mreq = mreq;
      v.page = pg; v.n_romcs = romcs; v.contended = cont;
      return v;
   endfunction

   task automatic apply_vec(input vec_t v, input string tag);
      logic [5:0] pg;
      logic       cs;
      logic       ct;
      @(negedge clkcpu);
      a      = v.a;
      n_mreq = v.n_mreq;
      #1;
      case (v.dut)
         0:       begin pg = {3'b000, page_128}; cs = romcs_128;  ct = cont_128;  end
         1:       begin pg = page_1024;          cs = romcs_1024; ct = cont_1024; end
         default: begin pg = {3'b000, page_p3};  cs = romcs_p3;   ct = cont_p3;   end
      endcase
      check($sformatf("%s a=%04h page", tag, v.a), 32'(pg), 32'(v.page));
      check($sformatf("%s a=%04h n_romcs", tag, v.a), 32'(cs), 32'(v.n_romcs));
      check($sformatf("%s a=%04h contended", tag, v.a), 32'(ct), 32'(v.contended));
   endtask

   task automatic run_table(input vec_t tbl[], input string tag);
      foreach (tbl[i]) apply_vec(tbl[i], tag);
   endtask

   task automatic do_reset();
      @(negedge clkcpu);
      rst_n = 1'b0;
      n_iorq = 1'b1; n_wr = 1'b1; n_mreq = 1'b1;
      repeat (2) @(negedge clkcpu);
      rst_n = 1'b1;
   endtask

   // IORQ+WR held across two rising edges: QUAL, then the load edge.
   task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clkcpu);
      a = addr; d = data; n_mreq = 1'b1; n_iorq = 1'b0; n_wr = 1'b0;
      repeat (2) @(negedge clkcpu);
      n_iorq = 1'b1; n_wr = 1'b1;
      @(negedge clkcpu);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl_reset[];
      vec_t tbl_128[];
      vec_t tbl_p3_cfg3[];
      vec_t tbl_p3_cfg1[];

      tbl_reset = new[4];
      tbl_reset[0] = mk(0, 16'hC000, 1'b0, 6'd0, 1'b1, 1'b0);
      tbl_reset[1] = mk(0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0);
      tbl_reset[2] = mk(0, 16'h0000, 1'b1, 6'd0, 1'b1, 1'b0);
      tbl_reset[3] = mk(2, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0);

      // After OUT #7FFD,#17: bank 7, rom_lo 1.
      tbl_128 = new[6];
      tbl_128[0] = mk(0, 16'hC000, 1'b0, 6'd7, 1'b1, 1'b1);
      tbl_128[1] = mk(0, 16'h4000, 1'b0, 6'd5, 1'b1, 1'b1);
      tbl_128[2] = mk(0, 16'h8000, 1'b0, 6'd2, 1'b1, 1'b0);
      tbl_128[3] = mk(0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0);
      tbl_128[4] = mk(0, 16'hC000, 1'b1, 6'd7, 1'b1, 1'b0);
      tbl_128[5] = mk(0, 16'h3FFF, 1'b1, 6'd0, 1'b1, 1'b0);

      // After OUT #1FFD,#07: special, cfg3 -> 4,7,6,3.
      tbl_p3_cfg3 = new[4];
      tbl_p3_cfg3[0] = mk(2, 16'h0000, 1'b0, 6'd4, 1'b1, 1'b1);
      tbl_p3_cfg3[1] = mk(2, 16'h4000, 1'b0, 6'd7, 1'b1, 1'b1);
      tbl_p3_cfg3[2] = mk(2, 16'h8000, 1'b0, 6'd6, 1'b1, 1'b1);
      tbl_p3_cfg3[3] = mk(2, 16'hC000, 1'b0, 6'd3, 1'b1, 1'b0);

      // After OUT #1FFD,#03: special, cfg1 -> 4,5,6,7.
      tbl_p3_cfg1 = new[4];
      tbl_p3_cfg1[0] = mk(2, 16'h0000, 1'b0, 6'd4, 1'b1, 1'b1);
      tbl_p3_cfg1[1] = mk(2, 16'h4000, 1'b0, 6'd5, 1'b1, 1'b1);
      tbl_p3_cfg1[2] = mk(2, 16'h8000, 1'b0, 6'd6, 1'b1, 1'b1);
      tbl_p3_cfg1[3] = mk(2, 16'hC000, 1'b0, 6'd7, 1'b1, 1'b1);

      // Reset state.
      do_reset();
      run_table(tbl_reset, "reset");
      check("reset rom_bank", 32'(rom_128), 32'd0);
      check("reset lock", 32'(lock_128), 32'd0);
      check("reset vbank", 32'(vbank_128), 32'd0);

      // Basic #7FFD write.
      io_write(16'h7FFD, 8'h17);
      run_table(tbl_128, "out17");
      check("out17 rom_bank", 32'(rom_128), 32'd1);
      check("out17 p3 rom_bank", 32'(rom_p3), 32'd1);

      // IORQ held for a single edge only: QUAL -> IDLE, no load.
      @(negedge clkcpu);
      a = 16'h7FFD; d = 8'h02; n_iorq = 1'b0; n_wr = 1'b0;
      @(negedge clkcpu);
      n_iorq = 1'b1; n_wr = 1'b1;
      apply_vec(mk(0, 16'hC000, 1'b0, 6'd7, 1'b1, 1'b1), "short_pulse");

      // Lock: second write ignored on locking variants, taken on 1024K.
      do_reset();
      io_write(16'h7FFD, 8'h20);
      io_write(16'h7FFD, 8'h03);
      io_write(16'h1FFD, 8'h01);
      check("lock 128 lock", 32'(lock_128), 32'd1);
      apply_vec(mk(0, 16'hC000, 1'b0, 6'd0, 1'b1, 1'b0), "locked128");
      check("lock 1024 lock", 32'(lock_1024), 32'd0);
      apply_vec(mk(1, 16'hC000, 1'b0, 6'd3, 1'b1, 1'b1), "unlocked1024");
      apply_vec(mk(2, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0), "locked_p3_1ffd");
      do_reset();
      check("lock cleared", 32'(lock_128), 32'd0);
      io_write(16'h7FFD, 8'h03);
      apply_vec(mk(0, 16'hC000, 1'b0, 6'd3, 1'b1, 1'b1), "after_unlock");

      // 6-bit bank gather.
      do_reset();
      io_write(16'h7FFD, 8'hE5);
      apply_vec(mk(1, 16'hC000, 1'b0, 6'h3D, 1'b1, 1'b1), "outE5");
      check("outE5 1024 lock", 32'(lock_1024), 32'd0);
      check("outE5 128 lock", 32'(lock_128), 32'd1);

      // +3 special paging.
      do_reset();
      io_write(16'h1FFD, 8'h07);
      run_table(tbl_p3_cfg3, "p3cfg3");
      check("p3cfg3 rom_bank", 32'(rom_p3), 32'd2);
      apply_vec(mk(0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0), "no1ffd_128");
      io_write(16'h1FFD, 8'h03);
      run_table(tbl_p3_cfg1, "p3cfg1");
      check("p3cfg1 rom_bank", 32'(rom_p3), 32'd0);
      io_write(16'h1FFD, 8'h04);
      apply_vec(mk(2, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0), "p3normal");
      check("p3normal rom_bank", 32'(rom_p3), 32'd2);

      // Wait states with data changing after the load edge.
      do_reset();
      @(negedge clkcpu);
      a = 16'h7FFD; d = 8'h17; n_iorq = 1'b0; n_wr = 1'b0;
      repeat (2) @(negedge clkcpu);
      d = 8'h0B;
      repeat (4) @(negedge clkcpu);
      n_iorq = 1'b1; n_wr = 1'b1;
      @(negedge clkcpu);
      apply_vec(mk(0, 16'hC000, 1'b0, 6'd7, 1'b1, 1'b1), "waitst");
      check("waitst vbank", 32'(vbank_128), 32'd0);
      check("waitst rom_bank", 32'(rom_128), 32'd1);

      // Reset asserted while the write sits in QUAL.
      @(negedge clkcpu);
      a = 16'h7FFD; d = 8'h1E; n_iorq = 1'b0; n_wr = 1'b0;
      @(negedge clkcpu);
      rst_n = 1'b0;
      @(negedge clkcpu);
      n_iorq = 1'b1; n_wr = 1'b1;
      @(negedge clkcpu);
      rst_n = 1'b1;
      repeat (2) @(negedge clkcpu);
      apply_vec(mk(0, 16'hC000, 1'b0, 6'd0, 1'b1, 1'b0), "rst_mid");
      check("rst_mid rom_bank", 32'(rom_128), 32'd0);
      io_write(16'h7FFD, 8'h08);
      check("vbank set", 32'(vbank_128), 32'd1);
      apply_vec(mk(0, 16'hC000, 1'b0, 6'd0, 1'b1, 1'b0), "vbank_page");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
